// File: rtl/udma_hyperbus_trans_splitter.sv
`default_nettype none
// ============================================================================
// Module   : udma_hyperbus_trans_splitter
// Purpose  : Sits in the PHY clock domain between the udma_hyperbus
//            controller trans_* outputs and the udma_hyperbus_phy trans_*
//            inputs. Splits one linear memory burst into consecutive chunks
//            that never cross a programmable 2^N-byte boundary, which bounds
//            CS-low time and keeps every PHY access inside one device page.
//            Wrapped bursts, register-space accesses and N=0 pass through as
//            a single chunk.
// Ports    : clk_phy_i / phy_rst_i     clock, synchronous active-high reset
//            cfg_chunk_log2_i          boundary exponent N (0 = off),
//                                      clamped to TRANS_SIZE-1
//            trans_*_i / trans_ready_o upstream request (valid/ready)
//            trans_*_o / trans_ready_i downstream chunk (valid/ready)
//            trans_last_o              final chunk of the request
//            trans_done_o              1-cycle pulse when the request retires
// Options  : HYPER_SPLIT_STATS_EN adds stat_chunks_o / stat_split_o,
//            saturating 16-bit counters cleared by phy_rst_i.
// Revision : 1.0 - initial release
// ============================================================================
module udma_hyperbus_trans_splitter #(
  parameter int NR_CS      = 2,
  parameter int TRANS_SIZE = 16
) (
  input  logic                  clk_phy_i,
  input  logic                  phy_rst_i,
  input  logic [4:0]            cfg_chunk_log2_i,
  input  logic                  trans_valid_i,
  output logic                  trans_ready_o,
  input  logic [31:0]           trans_address_i,
  input  logic [NR_CS-1:0]      trans_cs_i,
  input  logic                  trans_write_i,
  input  logic [TRANS_SIZE-1:0] trans_burst_i,
  input  logic                  trans_burst_type_i,
  input  logic                  trans_address_space_i,
  output logic                  trans_valid_o,
  input  logic                  trans_ready_i,
  output logic [31:0]           trans_address_o,
  output logic [NR_CS-1:0]      trans_cs_o,
  output logic                  trans_write_o,
  output logic [TRANS_SIZE-1:0] trans_burst_o,
  output logic                  trans_burst_type_o,
  output logic                  trans_address_space_o,
  output logic                  trans_last_o,
`ifdef HYPER_SPLIT_STATS_EN
  output logic [15:0]           stat_chunks_o,
  output logic [15:0]           stat_split_o,
`endif
  output logic                  trans_done_o
);

  localparam logic [4:0] C_MAX_LOG2 = 5'(TRANS_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  // Latched request context
  logic [31:0]           r_addr;
  logic [TRANS_SIZE-1:0] r_rem;
  logic [NR_CS-1:0]      r_cs;
  logic                  r_write;
  logic                  r_type;
  logic                  r_space;
  logic [4:0]            r_log2;

  // Registered chunk presented downstream
  logic [31:0]           r_out_addr;
  logic [TRANS_SIZE-1:0] r_out_burst;
  logic [NR_CS-1:0]      r_out_cs;
  logic                  r_out_write;
  logic                  r_out_type;
  logic                  r_out_space;
  logic                  r_out_last;
  logic                  r_done;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [4:0]            w_log2_clamped;
  logic                  w_no_split;
  logic [TRANS_SIZE-1:0] w_span;
  logic [TRANS_SIZE-1:0] w_bound;
  logic [TRANS_SIZE-1:0] w_chunk;

  assign w_in_fire  = trans_valid_i & (r_state == S_IDLE);
  assign w_out_fire = (r_state == S_ISSUE) & trans_ready_i;

  assign w_log2_clamped = (cfg_chunk_log2_i > C_MAX_LOG2) ? C_MAX_LOG2 : cfg_chunk_log2_i;

  // N is clamped below TRANS_SIZE, so 2^N and the distance to the next
  // boundary always fit in TRANS_SIZE bits; only the low address bits matter.
  assign w_no_split = (r_log2 == 5'd0) | ~r_type | r_space;
  assign w_span     = TRANS_SIZE'(1) << r_log2;
  assign w_bound    = w_span - (r_addr[TRANS_SIZE-1:0] & (w_span - TRANS_SIZE'(1)));
  assign w_chunk    = (w_no_split || (r_rem <= w_bound)) ? r_rem : w_bound;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_phy_i) begin
    if (phy_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A zero-length request retires from IDLE without touching the PHY
        if (w_in_fire && (trans_burst_i != '0)) w_state_next = S_CALC;
      end
      S_CALC:  w_state_next = S_ISSUE;
      S_ISSUE: begin
        if (trans_ready_i) w_state_next = r_out_last ? S_IDLE : S_CALC;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk_phy_i) begin
    if (phy_rst_i) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_cs        <= '0;
      r_write     <= 1'b0;
      r_type      <= 1'b0;
      r_space     <= 1'b0;
      r_log2      <= '0;
      r_out_addr  <= '0;
      r_out_burst <= '0;
      r_out_cs    <= '0;
      r_out_write <= 1'b0;
      r_out_type  <= 1'b0;
      r_out_space <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_fire) begin
        r_addr  <= trans_address_i;
        r_rem   <= trans_burst_i;
        r_cs    <= trans_cs_i;
        r_write <= trans_write_i;
        r_type  <= trans_burst_type_i;
        r_space <= trans_address_space_i;
        r_log2  <= w_log2_clamped;
        if (trans_burst_i == '0) r_done <= 1'b1;
      end
      if (r_state == S_CALC) begin
        r_out_addr  <= r_addr;
        r_out_burst <= w_chunk;
        r_out_cs    <= r_cs;
        r_out_write <= r_write;
        r_out_type  <= r_type;
        r_out_space <= r_space;
        r_out_last  <= (w_chunk == r_rem);
      end
      if (w_out_fire) begin
        // Address advance wraps modulo 2^32 by construction
        r_addr <= r_addr + {{(32-TRANS_SIZE){1'b0}}, r_out_burst};
        r_rem  <= r_rem - r_out_burst;
        if (r_out_last) r_done <= 1'b1;
      end
    end
  end

`ifdef HYPER_SPLIT_STATS_EN
  logic [15:0] r_stat_chunks;
  logic [15:0] r_stat_split;
  logic        r_first_chunk;

  // A request is counted as split when its first chunk is not also its last
  always_ff @(posedge clk_phy_i) begin
    if (phy_rst_i) begin
      r_stat_chunks <= '0;
      r_stat_split  <= '0;
      r_first_chunk <= 1'b0;
    end else begin
      if (w_in_fire) r_first_chunk <= 1'b1;
      if (w_out_fire) begin
        r_first_chunk <= 1'b0;
        if (r_stat_chunks != 16'hFFFF) r_stat_chunks <= r_stat_chunks + 16'd1;
        if (r_first_chunk && !r_out_last && (r_stat_split != 16'hFFFF))
          r_stat_split <= r_stat_split + 16'd1;
      end
    end
  end

  assign stat_chunks_o = r_stat_chunks;
  assign stat_split_o  = r_stat_split;
`else
  // Statistics counters are not built in this configuration
`endif

  // ------------------------------------------------------------ outputs
  assign trans_ready_o         = (r_state == S_IDLE);
  assign trans_valid_o         = (r_state == S_ISSUE);
  assign trans_last_o          = (r_state == S_ISSUE) & r_out_last;
  assign trans_address_o       = r_out_addr;
  assign trans_cs_o            = r_out_cs;
  assign trans_write_o         = r_out_write;
  assign trans_burst_o         = r_out_burst;
  assign trans_burst_type_o    = r_out_type;
  assign trans_address_space_o = r_out_space;
  assign trans_done_o          = r_done;

endmodule
`default_nettype wire
